// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for the N:1 round-robin packet arbiter.
// slave: arbiter side; master: producer/consumer environment side.
interface axis_rr_arbiter_if #(
   parameter int NUM_SRC    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int BUS_WIDTH  = 64
);
   localparam int WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH;

   logic [NUM_SRC-1:0]                s_valid;
   logic [NUM_SRC-1:0]                s_ready;
   logic [NUM_SRC-1:0]                s_last;
   logic [NUM_SRC*BUS_WIDTH-1:0]      s_data;
   logic [NUM_SRC*WORDS_PER_BEAT-1:0] s_keep;
   logic                              m_valid;
   logic                              m_ready;
   logic                              m_last;
   logic [BUS_WIDTH-1:0]              m_data;
   logic [WORDS_PER_BEAT-1:0]         m_keep;

   modport slave (
      input  s_valid, s_last, s_data, s_keep, m_ready,
      output s_ready, m_valid, m_last, m_data, m_keep
   );

   modport master (
      output s_valid, s_last, s_data, s_keep, m_ready,
      input  s_ready, m_valid, m_last, m_data, m_keep
   );
endinterface

// File: rtl/axis_rr_arbiter.sv
// N:1 AXI-Stream packet arbiter, round-robin, grant held for a whole packet.
// Define AXIS_ARB_ID_EN to export the granted source index on m_id.
module axis_rr_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int BUS_WIDTH  = 64,
   parameter int CNT_WIDTH  = 16,
   localparam int WPB       = BUS_WIDTH / WORD_WIDTH,
   localparam int ID_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   axis_rr_arbiter_if.slave     axis,
   output logic [CNT_WIDTH-1:0] pkt_count
`ifdef AXIS_ARB_ID_EN
   ,
   output logic [ID_WIDTH-1:0]  m_id
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ID_WIDTH-1:0]   grant_q;
   logic [ID_WIDTH-1:0]   grant_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q;
   logic [ID_WIDTH-1:0]   rr_ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic [ID_WIDTH-1:0]   hi_idx;
   logic                  hi_vld;
   logic [ID_WIDTH-1:0]   lo_idx;
   logic                  lo_vld;
   logic [ID_WIDTH-1:0]   pick;
   logic                  pick_vld;

   // round-robin pick: lowest requester above rr_ptr, else lowest overall
   always_comb begin
      hi_idx = '0;
      hi_vld = 1'b0;
      lo_idx = '0;
      lo_vld = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (axis.s_valid[i]) begin
            if (i > int'(rr_ptr_q)) begin
               if (!hi_vld) begin
                  hi_idx = ID_WIDTH'(i);
                  hi_vld = 1'b1;
               end
            end else if (!lo_vld) begin
               lo_idx = ID_WIDTH'(i);
               lo_vld = 1'b1;
            end
         end
      end
      pick     = hi_vld ? hi_idx : lo_idx;
      pick_vld = hi_vld | lo_vld;
   end

   // granted source passes straight through; nothing passes while idle
   always_comb begin
      axis.m_valid = 1'b0;
      axis.m_last  = 1'b0;
      axis.m_data  = '0;
      axis.m_keep  = '0;
      axis.s_ready = '0;
      if (state_q == BUSY) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
               axis.m_valid    = axis.s_valid[i];
               axis.m_last     = axis.s_last[i];
               axis.m_data     = axis.s_data[i*BUS_WIDTH +: BUS_WIDTH];
               axis.m_keep     = axis.s_keep[i*WPB +: WPB];
               axis.s_ready[i] = axis.m_ready;
            end
         end
      end
   end

   // arbitrate in IDLE, release the grant on the last beat of the packet
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = pkt_count;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (axis.m_valid && axis.m_ready && axis.m_last) begin
               state_d  = IDLE;
               rr_ptr_d = grant_q;
               cnt_d    = pkt_count + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, grant, pointer and packet counter registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= ID_WIDTH'(NUM_SRC - 1);
         pkt_count <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_count <= cnt_d;
      end
   end

`ifdef AXIS_ARB_ID_EN
   assign m_id = (state_q == BUSY) ? grant_q : '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter with a transaction-level model.
// Build with AXIS_ARB_ID_EN defined to also check m_id.
module tb_axis_rr_arbiter;
   localparam int NS  = 4;
   localparam int WW  = 8;
   localparam int BW  = 64;
   localparam int WPB = BW / WW;
   localparam int CW  = 4;
   localparam int IW  = 2;

   typedef struct packed {
      logic [BW-1:0]  d;
      logic [WPB-1:0] k;
      logic           l;
   } beat_t;

   logic          aclk   = 1'b0;
   logic          areset = 1'b1;
   logic [CW-1:0] pkt_count;
`ifdef AXIS_ARB_ID_EN
   logic [IW-1:0] m_id;
`endif

   axis_rr_arbiter_if #(.NUM_SRC(NS), .WORD_WIDTH(WW), .BUS_WIDTH(BW)) bus ();

   axis_rr_arbiter #(
      .NUM_SRC(NS), .WORD_WIDTH(WW), .BUS_WIDTH(BW), .CNT_WIDTH(CW)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .axis(bus),
      .pkt_count(pkt_count)
`ifdef AXIS_ARB_ID_EN
      ,
      .m_id(m_id)
`endif
   );

   always #5 aclk = ~aclk;

   int       checks = 0;
   int       errors = 0;
   int       cyc = 0;
   bit       run_chk = 1'b0;
   bit       busy = 1'b0;
   int       owner = 0;
   int       last_own = NS - 1;
   int       mcount = 0;
   logic [NS-1:0] acc = '0;
   int       order_q[$];
   int       hs_cyc[$];
   beat_t    pend[NS][$];
   beat_t    exp_q[NS][$];
   int       quota[NS];
   int       vp[NS];
   int       len_lo = 1;
   int       len_hi = 1;
   int       rprob = 100;
   logic [NS-1:0] er;
   logic     ev;
   beat_t    eb;

   task automatic chk(string name, logic [127:0] act, logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   // model: one owner per packet, next owner is first requester after last
   always @(negedge aclk) begin
      cyc++;
      acc = '0;
      if (run_chk) begin
         er = '0;
         ev = 1'b0;
         if (busy) begin
            ev        = bus.s_valid[owner];
            er[owner] = bus.m_ready;
         end
         chk("m_valid", bus.m_valid, ev);
         chk("s_ready", bus.s_ready, er);
         chk("pkt_count", pkt_count, mcount % (1 << CW));
`ifdef AXIS_ARB_ID_EN
         chk("m_id", m_id, busy ? owner : 0);
`endif
         if (!busy) begin
            chk("m_data_idle", bus.m_data, 0);
            chk("m_keep_idle", bus.m_keep, 0);
            chk("m_last_idle", bus.m_last, 0);
         end
         if (busy && ev && bus.m_ready) begin
            acc[owner] = 1'b1;
            hs_cyc.push_back(cyc);
            if (exp_q[owner].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_extra: got beat from src %0d, required none",
                        owner);
            end else begin
               eb = exp_q[owner].pop_front();
               chk("m_data", bus.m_data, eb.d);
               chk("m_keep", bus.m_keep, eb.k);
               chk("m_last", bus.m_last, eb.l);
               if (eb.l) begin
                  busy     = 1'b0;
                  last_own = owner;
                  mcount++;
               end
            end
         end else if (!busy && (|bus.s_valid)) begin
            for (int k = 1; k <= NS; k++) begin
               if (!busy && bus.s_valid[(last_own + k) % NS]) begin
                  owner = (last_own + k) % NS;
                  busy  = 1'b1;
               end
            end
            order_q.push_back(owner);
         end
      end
   end

   task automatic gen(int i);
      int    n;
      beat_t b;
      n = $urandom_range(len_hi, len_lo);
      quota[i]--;
      for (int j = 0; j < n; j++) begin
         b.d = {$urandom, $urandom};
         b.k = WPB'($urandom_range(255, 1));
         b.l = (j == n - 1);
         pend[i].push_back(b);
         exp_q[i].push_back(b);
      end
   endtask

   task automatic step();
      logic [NS*BW-1:0]  d;
      logic [NS*WPB-1:0] k;
      logic [NS-1:0]     v;
      logic [NS-1:0]     l;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
         if (pend[i].size() == 0 && quota[i] > 0) gen(i);
         if (pend[i].size() > 0 && $urandom_range(99) < vp[i]) begin
            v[i]            = 1'b1;
            d[i*BW +: BW]   = pend[i][0].d;
            k[i*WPB +: WPB] = pend[i][0].k;
            l[i]            = pend[i][0].l;
         end else begin
            v[i]            = 1'b0;
            d[i*BW +: BW]   = {$urandom, $urandom};
            k[i*WPB +: WPB] = WPB'($urandom);
            l[i]            = 1'($urandom);
         end
      end
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_keep  = k;
      bus.s_last  = l;
      bus.m_ready = ($urandom_range(99) < rprob);
   endtask

   function automatic bit all_done();
      if (busy) return 1'b0;
      for (int i = 0; i < NS; i++)
         if (quota[i] > 0 || pend[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while (!all_done()) begin
         if (n == budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, required drain",
                     name, budget);
            return;
         end
         step();
         n++;
      end
   endtask

   task automatic setup(int q0, int q1, int q2, int q3, int lo, int hi,
                        int v, int r);
      quota[0] = q0;
      quota[1] = q1;
      quota[2] = q2;
      quota[3] = q3;
      for (int i = 0; i < NS; i++) vp[i] = v;
      len_lo = lo;
      len_hi = hi;
      rprob  = r;
      order_q.delete();
      hs_cyc.delete();
   endtask

   int exp1[5] = '{0, 1, 2, 3, 0};
   int n5;

   initial begin
      for (int i = 0; i < NS; i++) begin
         quota[i] = 0;
         vp[i]    = 100;
      end
      bus.s_valid = '1;
      bus.s_last  = '1;
      bus.s_data  = '1;
      bus.s_keep  = '1;
      bus.m_ready = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_m_keep", bus.m_keep, 0);
      chk("rst_m_last", bus.m_last, 0);
      bus.s_valid = '0;
      @(posedge aclk);
      #1;
      areset  = 1'b0;
      run_chk = 1'b1;

      // all sources busy, 3-beat packets
      setup(2, 1, 1, 1, 3, 3, 100, 100);
      drain("p1", 200);
      chk("p1_npkt", order_q.size(), 5);
      for (int i = 0; i < order_q.size() && i < 5; i++)
         chk("p1_order", order_q[i], exp1[i]);
      chk("p1_beats", hs_cyc.size(), 15);
      if (hs_cyc.size() == 15)
         chk("p1_span", hs_cyc[14] - hs_cyc[0], 18);
      chk("p1_count", pkt_count, 5);

      // lone single-beat requester: one beat every two cycles
      setup(0, 0, 4, 0, 1, 1, 100, 100);
      drain("p2", 100);
      chk("p2_beats", hs_cyc.size(), 4);
      if (hs_cyc.size() == 4)
         chk("p2_span", hs_cyc[3] - hs_cyc[0], 6);
      foreach (order_q[i]) chk("p2_grant", order_q[i], 2);
      chk("p2_count", pkt_count, 9);

      // granted source stalls mid-packet while another requests
      setup(0, 1, 0, 0, 5, 5, 100, 100);
      step();
      step();
      quota[0] = 1;
      vp[1]    = 40;
      drain("p3", 400);
      chk("p3_npkt", order_q.size(), 2);
      if (order_q.size() == 2) begin
         chk("p3_first", order_q[0], 1);
         chk("p3_second", order_q[1], 0);
      end
      chk("p3_count", pkt_count, 11);

      // random sparse sources, random backpressure, counter wraps
      setup(25, 25, 25, 25, 1, 8, 5, 80);
      drain("p4", 60000);
      chk("p4_count", pkt_count, 15);

      // reset in the middle of a packet
      setup(0, 1, 0, 0, 4, 4, 100, 100);
      n5 = 0;
      while (hs_cyc.size() < 1 && n5 < 20) begin
         step();
         n5++;
      end
      chk("p5_started", hs_cyc.size(), 1);
      run_chk = 1'b0;
      areset  = 1'b1;
      #1;
      chk("p5_m_valid", bus.m_valid, 0);
      chk("p5_s_ready", bus.s_ready, 0);
      chk("p5_pkt_count", pkt_count, 0);
      for (int i = 0; i < NS; i++) begin
         pend[i].delete();
         exp_q[i].delete();
      end
      busy     = 1'b0;
      last_own = NS - 1;
      mcount   = 0;
      acc      = '0;
      setup(0, 1, 0, 1, 2, 2, 100, 100);
      step();
      areset  = 1'b0;
      run_chk = 1'b1;
      drain("p5", 100);
      chk("p5_npkt", order_q.size(), 2);
      if (order_q.size() == 2) begin
         chk("p5_first", order_q[0], 1);
         chk("p5_second", order_q[1], 3);
      end
      chk("p5_count", pkt_count, 2);

      run_chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
